mem_port_arbiter: RTL and testbench

- Shares one single-port, variable-latency memory between the instruction-fetch path and the load/store data path.
- The instruction fetch side is the PC/instruction block; it presents the PC as a read address. The data side presents loads and stores.
- Allows one outstanding transaction at a time. Data requests have priority, and a starvation counter guarantees that instruction fetch always makes progress.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory handshakes around mem_port_arbiter.
// master is the arbiter's view; slave is the requesters-plus-memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_gnt;
    logic                  i_rvalid;
    logic [DATA_W-1:0]     i_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_be;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    logic                  m_req;
    logic                  m_we;
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W/8-1:0]   m_be;
    logic                  m_gnt;
    logic                  m_rvalid;
    logic [DATA_W-1:0]     m_rdata;

    modport master (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  m_gnt, m_rvalid, m_rdata,
        output i_gnt, i_rvalid, i_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_addr, m_wdata, m_be
    );

    modport slave (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output m_gnt, m_rvalid, m_rdata,
        input  i_gnt, i_rvalid, i_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, m_be
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory shared by fetch and load/store, one transaction in flight.
// Data has priority; a starvation counter forces a fetch grant after MAX_WAIT.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);
    localparam int BE_W = DATA_W / 8;
    localparam int SW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
    typedef enum logic [1:0] {NONE, INSTR, DATA} owner_t;

    state_t          state;
    owner_t          owner;
    owner_t          sel;
    logic [SW-1:0]   starve;
    logic            starve_ok;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [BE_W-1:0]   m_be;
    logic              granted;
    logic              i_gnt;
    logic              d_gnt;
    logic              rsp_hit;

    // With MAX_WAIT=0 this is never true, so a pending fetch always wins.
    assign starve_ok = starve < STARVE_MAX;

    always_comb begin
        sel = NONE;
        case (state)
            IDLE: begin
                if (bus.d_req && (starve_ok || !bus.i_req)) begin
                    sel = DATA;
                end else if (bus.i_req) begin
                    sel = INSTR;
                end
            end
            REQ:     sel = owner;
            default: sel = NONE;
        endcase
    end

    always_comb begin
        m_req   = (sel != NONE);
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_be    = '0;
        if (sel == INSTR) begin
            m_addr = bus.i_addr;
            m_be   = '1;
        end else if (sel == DATA) begin
            m_we    = bus.d_we;
            m_addr  = bus.d_addr;
            m_wdata = bus.d_wdata;
            m_be    = bus.d_be;
        end
    end

    assign granted = m_req && bus.m_gnt;
    assign i_gnt   = granted && (sel == INSTR);
    assign d_gnt   = granted && (sel == DATA);
    assign rsp_hit = (state == RSP) && bus.m_rvalid;

    assign bus.m_req    = m_req;
    assign bus.m_we     = m_we;
    assign bus.m_addr   = m_addr;
    assign bus.m_wdata  = m_wdata;
    assign bus.m_be     = m_be;
    assign bus.i_gnt    = i_gnt;
    assign bus.d_gnt    = d_gnt;
    assign bus.i_rvalid = rsp_hit && (owner == INSTR);
    assign bus.d_rvalid = rsp_hit && (owner == DATA);
    assign bus.i_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= NONE;
            starve <= '0;
        end else begin
            case (state)
                IDLE, REQ: begin
                    if (granted) begin
                        state <= m_we ? IDLE : RSP;
                        owner <= m_we ? NONE : sel;
                    end else if (m_req) begin
                        // Lock the owner until the memory accepts it.
                        state <= REQ;
                        owner <= sel;
                    end
                end
                RSP: begin
                    if (bus.m_rvalid) begin
                        state <= IDLE;
                        owner <= NONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    owner <= NONE;
                end
            endcase

            if (!bus.i_req || i_gnt) begin
                starve <= '0;
            end else if (d_gnt && starve_ok) begin
                starve <= starve + SW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, load, store, starvation,
// owner lock under backpressure and reset during an outstanding read.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_WAIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; checks run 4ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.i_req    = 1'b0;
        bus.i_addr   = '0;
        bus.d_req    = 1'b0;
        bus.d_we     = 1'b0;
        bus.d_addr   = '0;
        bus.d_wdata  = 32'hA5A5A5A5;
        bus.d_be     = 4'b0000;
        bus.m_gnt    = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = '0;
    endtask

    task automatic test_reset();
        quiet();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.m_rvalid = 1'b1;
        #4;
        checks++;
        if (bus.m_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_m_req got %b want 0", bus.m_req);
        end
        checks++;
        if ({bus.i_gnt, bus.d_gnt} !== 2'b00) begin
            errors++;
            $display("FAIL reset_gnt got %b want 00", {bus.i_gnt, bus.d_gnt});
        end
        checks++;
        if ({bus.i_rvalid, bus.d_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_rvalid got %b want 00",
                     {bus.i_rvalid, bus.d_rvalid});
        end
        tick();
        bus.m_rvalid = 1'b0;
    endtask

    task automatic test_single_fetch();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h10;
        bus.m_gnt  = 1'b1;
        #4;
        checks++;
        if ({bus.i_gnt, bus.d_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_gnt got %b want 10", {bus.i_gnt, bus.d_gnt});
        end
        checks++;
        if ({bus.m_req, bus.m_we, bus.m_addr} !== {2'b10, 32'h10}) begin
            errors++;
            $display("FAIL fetch_req got %b/%b/%h want 1/0/00000010",
                     bus.m_req, bus.m_we, bus.m_addr);
        end
        checks++;
        if ({bus.m_be, bus.m_wdata} !== {4'hF, 32'h0}) begin
            errors++;
            $display("FAIL fetch_be_wdata got %h/%h want f/00000000",
                     bus.m_be, bus.m_wdata);
        end
        tick();
        bus.i_req = 1'b0;
        bus.m_gnt = 1'b0;
        #4;
        checks++;
        if ({bus.m_req, bus.i_rvalid, bus.d_gnt} !== 3'b000) begin
            errors++;
            $display("FAIL fetch_wait got %b want 000",
                     {bus.m_req, bus.i_rvalid, bus.d_gnt});
        end
        tick();
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'h00500093;
        #4;
        checks++;
        if ({bus.i_rvalid, bus.d_rvalid} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_rvalid got %b want 10",
                     {bus.i_rvalid, bus.d_rvalid});
        end
        checks++;
        if (bus.i_rdata !== 32'h00500093) begin
            errors++;
            $display("FAIL fetch_rdata got %h want 00500093", bus.i_rdata);
        end
        tick();
        bus.m_rvalid = 1'b0;
        #4;
        checks++;
        if (bus.i_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_pulse got %b want 0", bus.i_rvalid);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h40;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h200;
        bus.m_gnt  = 1'b1;
        #4;
        checks++;
        if ({bus.d_gnt, bus.i_gnt, bus.m_addr} !== {2'b10, 32'h200}) begin
            errors++;
            $display("FAIL sim_data_first got %b/%b/%h want 1/0/00000200",
                     bus.d_gnt, bus.i_gnt, bus.m_addr);
        end
        tick();
        bus.d_req = 1'b0;
        bus.m_gnt = 1'b0;
        tick();
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'h12345678;
        #4;
        checks++;
        if ({bus.d_rvalid, bus.i_rvalid, bus.m_req} !== 3'b100) begin
            errors++;
            $display("FAIL sim_d_rvalid got %b want 100",
                     {bus.d_rvalid, bus.i_rvalid, bus.m_req});
        end
        tick();
        bus.m_rvalid = 1'b0;
        bus.m_gnt    = 1'b1;
        #4;
        checks++;
        if ({bus.i_gnt, bus.m_addr} !== {1'b1, 32'h40}) begin
            errors++;
            $display("FAIL sim_fetch_next got %b/%h want 1/00000040",
                     bus.i_gnt, bus.m_addr);
        end
        tick();
        bus.i_req = 1'b0;
        bus.m_gnt = 1'b0;
        tick();
        bus.m_rvalid = 1'b1;
        tick();
        bus.m_rvalid = 1'b0;
    endtask

    task automatic test_store();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h300;
        bus.d_be    = 4'b0011;
        bus.d_wdata = 32'hDEADBEEF;
        bus.m_gnt   = 1'b1;
        #4;
        checks++;
        if ({bus.d_gnt, bus.m_we, bus.m_be} !== {2'b11, 4'b0011}) begin
            errors++;
            $display("FAIL store_req got %b/%b/%b want 1/1/0011",
                     bus.d_gnt, bus.m_we, bus.m_be);
        end
        checks++;
        if (bus.m_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_wdata got %h want deadbeef", bus.m_wdata);
        end
        tick();
        bus.d_req    = 1'b0;
        bus.m_gnt    = 1'b0;
        bus.m_rvalid = 1'b1;
        #4;
        checks++;
        if ({bus.d_rvalid, bus.m_req} !== 2'b00) begin
            errors++;
            $display("FAIL store_no_rvalid got %b want 00",
                     {bus.d_rvalid, bus.m_req});
        end
        tick();
        bus.m_rvalid = 1'b0;
        bus.d_req    = 1'b1;
        bus.d_we     = 1'b0;
        bus.d_addr   = 32'h304;
        bus.m_gnt    = 1'b1;
        #4;
        checks++;
        if (bus.d_gnt !== 1'b1) begin
            errors++;
            $display("FAIL store_then_idle got %b want 1", bus.d_gnt);
        end
        tick();
        bus.d_req = 1'b0;
        bus.m_gnt = 1'b0;
        tick();
        bus.m_rvalid = 1'b1;
        tick();
        bus.m_rvalid = 1'b0;
    endtask

    task automatic test_starvation();
        logic [1:0] want;
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h80;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h500;
        bus.d_be    = 4'hF;
        bus.m_gnt   = 1'b1;
        for (int round = 0; round < 2; round++) begin
            for (int k = 0; k < 5; k++) begin
                want = (k < 4) ? 2'b01 : 2'b10;
                #4;
                checks++;
                if ({bus.i_gnt, bus.d_gnt} !== want) begin
                    errors++;
                    $display("FAIL starve_r%0d_c%0d got %b want %b",
                             round, k, {bus.i_gnt, bus.d_gnt}, want);
                end
                tick();
            end
            bus.m_gnt = 1'b0;
            #4;
            checks++;
            if (bus.m_req !== 1'b0) begin
                errors++;
                $display("FAIL starve_rsp_r%0d got %b want 0", round, bus.m_req);
            end
            tick();
            bus.m_rvalid = 1'b1;
            #4;
            checks++;
            if (bus.i_rvalid !== 1'b1) begin
                errors++;
                $display("FAIL starve_irv_r%0d got %b want 1", round, bus.i_rvalid);
            end
            tick();
            bus.m_rvalid = 1'b0;
            bus.m_gnt    = 1'b1;
        end
        quiet();
        tick();
    endtask

    task automatic test_lock();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h80;
        bus.m_gnt  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                bus.d_req  = 1'b1;
                bus.d_we   = 1'b0;
                bus.d_addr = 32'h400;
            end
            #4;
            checks++;
            if ({bus.m_req, bus.m_addr, bus.i_gnt, bus.d_gnt}
                    !== {1'b1, 32'h80, 2'b00}) begin
                errors++;
                $display("FAIL lock_c%0d got %b/%h/%b/%b want 1/00000080/0/0",
                         k, bus.m_req, bus.m_addr, bus.i_gnt, bus.d_gnt);
            end
            tick();
        end
        bus.m_gnt = 1'b1;
        #4;
        checks++;
        if ({bus.i_gnt, bus.d_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL lock_gnt got %b want 10", {bus.i_gnt, bus.d_gnt});
        end
        tick();
        bus.i_req = 1'b0;
        bus.m_gnt = 1'b0;
        tick();
        bus.m_rvalid = 1'b1;
        tick();
        bus.m_rvalid = 1'b0;
        bus.m_gnt    = 1'b1;
        #4;
        checks++;
        if ({bus.d_gnt, bus.m_addr} !== {1'b1, 32'h400}) begin
            errors++;
            $display("FAIL lock_data_after got %b/%h want 1/00000400",
                     bus.d_gnt, bus.m_addr);
        end
        tick();
        bus.d_req = 1'b0;
        bus.m_gnt = 1'b0;
        tick();
        bus.m_rvalid = 1'b1;
        #4;
        checks++;
        if ({bus.d_rvalid, bus.i_rvalid} !== 2'b10) begin
            errors++;
            $display("FAIL lock_d_rvalid got %b want 10",
                     {bus.d_rvalid, bus.i_rvalid});
        end
        tick();
        bus.m_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h20;
        bus.m_gnt  = 1'b1;
        tick();
        bus.i_req = 1'b0;
        bus.m_gnt = 1'b0;
        rst       = 1'b1;
        tick();
        rst          = 1'b0;
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'hBADBAD00;
        #4;
        checks++;
        if ({bus.i_rvalid, bus.d_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL rst_late_rvalid got %b want 00",
                     {bus.i_rvalid, bus.d_rvalid});
        end
        tick();
        bus.m_rvalid = 1'b0;
        bus.i_req    = 1'b1;
        bus.i_addr   = 32'h24;
        bus.m_gnt    = 1'b1;
        #4;
        checks++;
        if ({bus.i_gnt, bus.m_addr} !== {1'b1, 32'h24}) begin
            errors++;
            $display("FAIL rst_new_fetch got %b/%h want 1/00000024",
                     bus.i_gnt, bus.m_addr);
        end
        tick();
        bus.i_req = 1'b0;
        bus.m_gnt = 1'b0;
        tick();
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'h00000013;
        #4;
        checks++;
        if ({bus.i_rvalid, bus.i_rdata} !== {1'b1, 32'h13}) begin
            errors++;
            $display("FAIL rst_fetch_rvalid got %b/%h want 1/00000013",
                     bus.i_rvalid, bus.i_rdata);
        end
        tick();
        bus.m_rvalid = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        quiet();
        #1;
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_store();
        test_starvation();
        test_lock();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
